// File: rtl/i2c_addr_decode_ctrl.sv
// I2C slave address-phase controller: synchronises SCL/SDA, detects START/STOP,
// shifts in the 7-bit address plus R/W, ACKs a matching address and flags the data phase.
module i2c_addr_decode_ctrl #(
    parameter logic [6:0] SLAVE_ADDR  = 7'h42,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       FPGA_clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic       start_det,
    output logic       stop_det,
    output logic       busy,
    output logic       addr_match,
    output logic       rw,
    output logic [2:0] bit_cnt
);

    typedef enum logic [2:0] {IDLE = 3'd0, ADDR, ACK, XFER, IGNORE} state_t;

    logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
    logic                   scl_s, sda_s;
    logic                   scl_p_q, sda_p_q;
    logic                   rise_q, fall_q, start_q, stop_q, sda_e_q;

    state_t     state_q, state_d;
    logic       sda_oe_q, sda_oe_d;
    logic       start_det_q, start_det_d;
    logic       stop_det_q, stop_det_d;
    logic       busy_q, busy_d;
    logic       addr_match_q, addr_match_d;
    logic       rw_q, rw_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] shift_q, shift_d;
    logic       full_q, full_d;

    assign scl_s = scl_sync_q[SYNC_STAGES-1];
    assign sda_s = sda_sync_q[SYNC_STAGES-1];

    // Synchronisers and edge history reset to 1 (idle bus) so reset release is edge-free.
    // Bus events are registered once more so every event sees a consistent SDA sample.
    always_ff @(posedge FPGA_clk) begin
        if (!rst_n) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_p_q    <= 1'b1;
            sda_p_q    <= 1'b1;
            rise_q     <= 1'b0;
            fall_q     <= 1'b0;
            start_q    <= 1'b0;
            stop_q     <= 1'b0;
            sda_e_q    <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_in};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_in};
            scl_p_q    <= scl_s;
            sda_p_q    <= sda_s;
            rise_q     <= scl_s & ~scl_p_q;
            fall_q     <= ~scl_s & scl_p_q;
            start_q    <= sda_p_q & ~sda_s & scl_s;
            stop_q     <= ~sda_p_q & sda_s & scl_s;
            sda_e_q    <= sda_s;
        end
    end

    always_ff @(posedge FPGA_clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            sda_oe_q     <= 1'b0;
            start_det_q  <= 1'b0;
            stop_det_q   <= 1'b0;
            busy_q       <= 1'b0;
            addr_match_q <= 1'b0;
            rw_q         <= 1'b0;
            cnt_q        <= 3'd0;
            shift_q      <= 8'd0;
            full_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            sda_oe_q     <= sda_oe_d;
            start_det_q  <= start_det_d;
            stop_det_q   <= stop_det_d;
            busy_q       <= busy_d;
            addr_match_q <= addr_match_d;
            rw_q         <= rw_d;
            cnt_q        <= cnt_d;
            shift_q      <= shift_d;
            full_q       <= full_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        sda_oe_d     = sda_oe_q;
        start_det_d  = 1'b0;
        stop_det_d   = 1'b0;
        busy_d       = busy_q;
        addr_match_d = addr_match_q;
        rw_d         = rw_q;
        cnt_d        = cnt_q;
        shift_d      = shift_q;
        full_d       = full_q;

        if (!en) begin
            state_d      = IDLE;
            sda_oe_d     = 1'b0;
            busy_d       = 1'b0;
            addr_match_d = 1'b0;
            cnt_d        = 3'd0;
            full_d       = 1'b0;
        end else if (stop_q) begin
            state_d      = IDLE;
            stop_det_d   = 1'b1;
            sda_oe_d     = 1'b0;
            busy_d       = 1'b0;
            addr_match_d = 1'b0;
            cnt_d        = 3'd0;
            full_d       = 1'b0;
        end else if (start_q) begin
            state_d      = ADDR;
            start_det_d  = 1'b1;
            sda_oe_d     = 1'b0;
            busy_d       = 1'b1;
            addr_match_d = 1'b0;
            cnt_d        = 3'd0;
            shift_d      = 8'd0;
            full_d       = 1'b0;
        end else begin
            case (state_q)
                ADDR: begin
                    if (rise_q) begin
                        shift_d = {shift_q[6:0], sda_e_q};
                        cnt_d   = cnt_q + 3'd1;
                        if (cnt_q == 3'd7) full_d = 1'b1;
                    end else if (fall_q && full_q) begin
                        // Falling edge after the R/W bit opens the ACK slot
                        full_d = 1'b0;
                        if (shift_q[7:1] == SLAVE_ADDR) begin
                            state_d  = ACK;
                            sda_oe_d = 1'b1;
                            rw_d     = shift_q[0];
                        end else begin
                            state_d = IGNORE;
                        end
                    end
                end
                ACK: begin
                    if (fall_q) begin
                        sda_oe_d     = 1'b0;
                        addr_match_d = 1'b1;
                        state_d      = XFER;
                    end
                end
                default: ;
            endcase
        end
    end

    assign sda_oe     = sda_oe_q;
    assign start_det  = start_det_q;
    assign stop_det   = stop_det_q;
    assign busy       = busy_q;
    assign addr_match = addr_match_q;
    assign rw         = rw_q;
    assign bit_cnt    = cnt_q;

endmodule

// File: tb/tb_i2c_addr_decode_ctrl.sv
// Bench for i2c_addr_decode_ctrl: bit-banged I2C master with an open-drain SDA line;
// expectations come from the I2C address/ACK rules applied to each transmitted byte.
`timescale 1ns/1ps
module tb_i2c_addr_decode_ctrl;
    localparam logic [6:0] SLAVE = 7'h42;
    localparam int         HALF  = 10;   // quarter of a 40-cycle SCL period

    logic       clk = 1'b0;
    logic       rst_n, en, scl_m, sda_m;
    logic       scl_in, sda_in;
    logic       sda_oe, start_det, stop_det, busy, addr_match, rw;
    logic [2:0] bit_cnt;

    int checks = 0;
    int fails  = 0;
    int start_cnt = 0, stop_cnt = 0, oe_cycles = 0;

    assign scl_in = scl_m;
    assign sda_in = sda_m & ~sda_oe;

    i2c_addr_decode_ctrl #(.SLAVE_ADDR(SLAVE), .SYNC_STAGES(2)) dut (
        .FPGA_clk(clk), .rst_n(rst_n), .en(en), .scl_in(scl_in), .sda_in(sda_in),
        .sda_oe(sda_oe), .start_det(start_det), .stop_det(stop_det), .busy(busy),
        .addr_match(addr_match), .rw(rw), .bit_cnt(bit_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (start_det === 1'b1) start_cnt++;
        if (stop_det === 1'b1)  stop_cnt++;
        if (sda_oe === 1'b1)    oe_cycles++;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One SCL clock; SDA changes only while SCL is low.
    task automatic send_bit(input logic b, input int k, input string tag);
        sda_m = b;
        wait_clk(HALF);
        scl_m = 1'b1;
        wait_clk(HALF);
        if (k >= 0) begin
            checks++;
            if (bit_cnt !== 3'(k % 8)) begin
                fails++;
                $display("FAIL %s bit_cnt after rise %0d: got %0d expected %0d", tag, k, bit_cnt, k % 8);
            end
        end
        wait_clk(HALF);
        scl_m = 1'b0;
        wait_clk(HALF);
    endtask

    task automatic do_start();
        sda_m = 1'b1; wait_clk(HALF);
        scl_m = 1'b1; wait_clk(HALF);
        sda_m = 1'b0; wait_clk(HALF);
        scl_m = 1'b0; wait_clk(HALF);
    endtask

    task automatic do_stop();
        sda_m = 1'b0; wait_clk(HALF);
        scl_m = 1'b1; wait_clk(HALF);
        sda_m = 1'b1; wait_clk(HALF);
    endtask

    // START, address byte, ACK slot and one data byte; leaves SCL low.
    task automatic addr_phase(input logic [7:0] b, input string tag);
        int   s0, oe0;
        logic exp_ack;
        exp_ack = (b[7:1] == SLAVE);
        s0  = start_cnt;
        oe0 = oe_cycles;
        do_start();
        checks++;
        if (start_cnt !== s0 + 1) begin
            fails++;
            $display("FAIL %s start_det pulses: got %0d expected 1", tag, start_cnt - s0);
        end
        checks++;
        if ({busy, bit_cnt, addr_match, sda_oe} !== 6'b1_000_0_0) begin
            fails++;
            $display("FAIL %s after START {busy,bit_cnt,match,oe}: got %b expected 100000", tag,
                     {busy, bit_cnt, addr_match, sda_oe});
        end
        for (int i = 0; i < 8; i++) send_bit(b[7-i], i + 1, tag);
        checks++;
        if (sda_oe !== exp_ack) begin
            fails++;
            $display("FAIL %s sda_oe after 8th fall: got %b expected %b", tag, sda_oe, exp_ack);
        end
        sda_m = 1'b1; wait_clk(HALF);
        scl_m = 1'b1; wait_clk(HALF);
        checks++;
        if (sda_oe !== exp_ack) begin
            fails++;
            $display("FAIL %s sda_oe in 9th SCL high: got %b expected %b", tag, sda_oe, exp_ack);
        end
        wait_clk(HALF);
        scl_m = 1'b0; wait_clk(HALF);
        checks++;
        if ({sda_oe, addr_match, busy} !== {1'b0, exp_ack, 1'b1}) begin
            fails++;
            $display("FAIL %s after ACK {oe,match,busy}: got %b expected %b", tag,
                     {sda_oe, addr_match, busy}, {1'b0, exp_ack, 1'b1});
        end
        checks++;
        if (oe_cycles - oe0 !== (exp_ack ? 40 : 0)) begin
            fails++;
            $display("FAIL %s sda_oe width: got %0d expected %0d", tag, oe_cycles - oe0, exp_ack ? 40 : 0);
        end
        if (exp_ack) begin
            checks++;
            if (rw !== b[0]) begin
                fails++;
                $display("FAIL %s rw: got %b expected %b", tag, rw, b[0]);
            end
        end
        for (int i = 0; i < 9; i++) send_bit(1'($urandom_range(0, 1)), -1, tag);
        checks++;
        if ({addr_match, sda_oe, busy, bit_cnt} !== {exp_ack, 1'b0, 1'b1, 3'd0} ||
            oe_cycles - oe0 !== (exp_ack ? 40 : 0)) begin
            fails++;
            $display("FAIL %s data phase {match,oe,busy,cnt}: got %b expected %b", tag,
                     {addr_match, sda_oe, busy, bit_cnt}, {exp_ack, 1'b0, 1'b1, 3'd0});
        end
        if (exp_ack) begin
            checks++;
            if (rw !== b[0]) begin
                fails++;
                $display("FAIL %s rw held in data phase: got %b expected %b", tag, rw, b[0]);
            end
        end
        $display("txn %s byte=%02h ack=%0d", tag, b, exp_ack);
    endtask

    task automatic finish_txn(input string tag);
        int p;
        p = stop_cnt;
        do_stop();
        checks++;
        if (stop_cnt !== p + 1) begin
            fails++;
            $display("FAIL %s stop_det pulses: got %0d expected 1", tag, stop_cnt - p);
        end
        checks++;
        if ({busy, addr_match, sda_oe, bit_cnt} !== 6'd0) begin
            fails++;
            $display("FAIL %s after STOP {busy,match,oe,cnt}: got %b expected 000000", tag,
                     {busy, addr_match, sda_oe, bit_cnt});
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        wait_clk(3);
        checks++;
        if ({sda_oe, start_det, stop_det, busy, addr_match, rw, bit_cnt} !== 9'd0) begin
            fails++;
            $display("FAIL reset outputs: got %b expected 0", {sda_oe, start_det, stop_det, busy, addr_match, rw, bit_cnt});
        end
        rst_n = 1'b1;
        wait_clk(10);
        checks++;
        if ({sda_oe, busy, bit_cnt} !== 5'd0 || start_cnt !== 0 || stop_cnt !== 0) begin
            fails++;
            $display("FAIL reset release activity: got starts=%0d stops=%0d busy=%b expected none", start_cnt, stop_cnt, busy);
        end
        $display("txn reset");
    endtask

    task automatic test_match_write();
        addr_phase(8'h84, "write");
        finish_txn("write");
    endtask

    task automatic test_match_read();
        addr_phase(8'h85, "read");
        finish_txn("read");
    endtask

    task automatic test_mismatch();
        addr_phase(8'hA0, "mismatch");
        finish_txn("mismatch");
    endtask

    task automatic test_rep_start();
        do_start();
        for (int i = 0; i < 4; i++) send_bit(1'($urandom_range(0, 1)), i + 1, "rep_start");
        checks++;
        if (bit_cnt !== 3'd4) begin
            fails++;
            $display("FAIL rep_start bit_cnt before Sr: got %0d expected 4", bit_cnt);
        end
        addr_phase(8'h84, "rep_start");
        finish_txn("rep_start");
    endtask

    task automatic test_stop_mid();
        int s0, oe0;
        do_start();
        for (int i = 0; i < 3; i++) send_bit(1'($urandom_range(0, 1)), i + 1, "stop_mid");
        finish_txn("stop_mid");
        s0  = start_cnt;
        oe0 = oe_cycles;
        scl_m = 1'b0; wait_clk(HALF);
        for (int i = 0; i < 10; i++) send_bit(1'($urandom_range(0, 1)), -1, "stop_mid");
        sda_m = 1'b1; wait_clk(HALF);
        scl_m = 1'b1; wait_clk(HALF);
        checks++;
        if (start_cnt !== s0 || oe_cycles !== oe0 || {busy, bit_cnt, addr_match} !== 5'd0) begin
            fails++;
            $display("FAIL stop_mid idle toggling: got starts=%0d oe=%0d busy=%b cnt=%0d expected no activity",
                     start_cnt - s0, oe_cycles - oe0, busy, bit_cnt);
        end
        $display("txn stop_mid");
    endtask

    task automatic test_reset_ack();
        int s0;
        do_start();
        for (int i = 0; i < 8; i++) send_bit(1'(8'h84 >> (7 - i)), i + 1, "reset_ack");
        checks++;
        if (sda_oe !== 1'b1) begin
            fails++;
            $display("FAIL reset_ack sda_oe before reset: got %b expected 1", sda_oe);
        end
        rst_n = 1'b0;
        wait_clk(1);
        checks++;
        if ({sda_oe, start_det, stop_det, busy, addr_match, rw, bit_cnt} !== 9'd0) begin
            fails++;
            $display("FAIL reset_ack outputs after reset: got %b expected 0",
                     {sda_oe, start_det, stop_det, busy, addr_match, rw, bit_cnt});
        end
        rst_n = 1'b1;
        s0 = start_cnt;
        for (int i = 0; i < 9; i++) send_bit(1'($urandom_range(0, 1)), -1, "reset_ack");
        checks++;
        if (start_cnt !== s0 || {busy, addr_match, sda_oe, bit_cnt} !== 6'd0) begin
            fails++;
            $display("FAIL reset_ack resume: got starts=%0d {busy,match,oe,cnt}=%b expected idle",
                     start_cnt - s0, {busy, addr_match, sda_oe, bit_cnt});
        end
        finish_txn("reset_ack");
        $display("txn reset_ack");
    endtask

    task automatic test_en_xfer();
        addr_phase(8'h84, "en_xfer");
        en = 1'b0;
        wait_clk(1);
        checks++;
        if ({addr_match, busy, sda_oe} !== 3'b000) begin
            fails++;
            $display("FAIL en_xfer after en=0 {match,busy,oe}: got %b expected 000", {addr_match, busy, sda_oe});
        end
        en = 1'b1;
        for (int i = 0; i < 2; i++) send_bit(1'($urandom_range(0, 1)), -1, "en_xfer");
        checks++;
        if ({addr_match, busy, bit_cnt} !== 5'd0) begin
            fails++;
            $display("FAIL en_xfer stays idle: got %b expected 0", {addr_match, busy, bit_cnt});
        end
        finish_txn("en_xfer");
    endtask

    task automatic test_random();
        logic [6:0] a;
        logic [7:0] b;
        for (int n = 0; n < 6; n++) begin
            a = ($urandom_range(0, 1) == 1) ? SLAVE : 7'($urandom_range(0, 127));
            b = {a, 1'($urandom_range(0, 1))};
            addr_phase(b, "random");
            finish_txn("random");
        end
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b1;
        scl_m = 1'b1;
        sda_m = 1'b1;
        test_reset();
        test_match_write();
        test_match_read();
        test_mismatch();
        test_rep_start();
        test_stop_mid();
        test_reset_ack();
        test_en_xfer();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
